// File: rtl/multiplication_seq_led_board.sv
// Sequential 8x8 shift-add multiplier with a scanned four-digit 7-segment display.
// Define MULT_SIGNED_EN to treat a and b as two's complement (sign-magnitude internally).
module multiplication_seq_led_board #(
  parameter int SCAN_DIV = 50000,
  parameter int WIDTH    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [6:0]       out,
  output logic             led1,
  output logic             led2,
  output logic             led3,
  output logic             led4
);

  localparam int PW = 2 * WIDTH;
  localparam int BW = $clog2(WIDTH);
  localparam int CW = $clog2(SCAN_DIV);

  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, CALC = 2'd2, FIN = 2'd3} state_t;

  state_t          state;
  state_t          next_state;
  logic            sync1, sync2, sync3;
  logic            start_pulse;
  logic            load_en, calc_en, fin_en;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [PW-1:0]   acc;
  logic [PW-1:0]   product;
  logic [BW-1:0]   bit_cnt;
  logic [WIDTH:0]  sum;
  logic [CW-1:0]   scan_cnt;
  logic [1:0]      digit;
  logic [3:0]      nibble;
  logic [3:0]      leds;
`ifdef MULT_SIGNED_EN
  logic            neg;
`endif

  function automatic logic [6:0] seg_decode(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'b0111111;
      4'h1: s = 7'b0000110;
      4'h2: s = 7'b1011011;
      4'h3: s = 7'b1001111;
      4'h4: s = 7'b1100110;
      4'h5: s = 7'b1101101;
      4'h6: s = 7'b1111101;
      4'h7: s = 7'b0000111;
      4'h8: s = 7'b1111111;
      4'h9: s = 7'b1101111;
      4'hA: s = 7'b1110111;
      4'hB: s = 7'b1111100;
      4'hC: s = 7'b0111001;
      4'hD: s = 7'b1011110;
      4'hE: s = 7'b1111001;
      4'hF: s = 7'b1110001;
      default: s = 7'b0000000;
    endcase
    return s;
  endfunction

  // Start button synchronizer; the third stage only serves edge detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      {sync1, sync2, sync3} <= 3'b000;
    end else begin
      {sync1, sync2, sync3} <= {start, sync1, sync2};
    end
  end

  assign start_pulse = sync2 & ~sync3;

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // FSM next-state logic; start pulses outside IDLE/FIN are dropped.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (start_pulse) next_state = LOAD; else next_state = IDLE;
      LOAD: next_state = CALC;
      CALC: if (bit_cnt == BW'(WIDTH - 1)) next_state = FIN; else next_state = CALC;
      FIN:  if (start_pulse) next_state = LOAD; else next_state = FIN;
      default: next_state = IDLE;
    endcase
  end

  // FSM output decode into datapath enables.
  always_comb begin
    load_en = 1'b0;
    calc_en = 1'b0;
    fin_en  = 1'b0;
    case (state)
      LOAD:    load_en = 1'b1;
      CALC:    calc_en = 1'b1;
      FIN:     fin_en  = 1'b1;
      default: load_en = 1'b0;
    endcase
  end

  assign sum = {1'b0, acc[PW-1:WIDTH]} + {1'b0, (mplier[0] ? mcand : {WIDTH{1'b0}})};

  // Multiplier datapath: product only updates in FIN so the display never sees partial sums.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mcand   <= '0;
      mplier  <= '0;
      acc     <= '0;
      bit_cnt <= '0;
      product <= '0;
      done    <= 1'b0;
`ifdef MULT_SIGNED_EN
      neg     <= 1'b0;
`endif
    end else if (load_en) begin
`ifdef MULT_SIGNED_EN
      mcand   <= a[WIDTH-1] ? ((~a) + {{(WIDTH-1){1'b0}}, 1'b1}) : a;
      mplier  <= b[WIDTH-1] ? ((~b) + {{(WIDTH-1){1'b0}}, 1'b1}) : b;
      neg     <= a[WIDTH-1] ^ b[WIDTH-1];
`else
      mcand   <= a;
      mplier  <= b;
`endif
      acc     <= '0;
      bit_cnt <= '0;
      done    <= 1'b0;
    end else if (calc_en) begin
      acc     <= {sum, acc[WIDTH-1:1]};
      mplier  <= {1'b0, mplier[WIDTH-1:1]};
      bit_cnt <= bit_cnt + BW'(1);
    end else if (fin_en) begin
`ifdef MULT_SIGNED_EN
      product <= neg ? ((~acc) + {{(PW-1){1'b0}}, 1'b1}) : acc;
`else
      product <= acc;
`endif
      done    <= 1'b1;
    end else begin
      done    <= done;
    end
  end

  // Display scan timer and digit index.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scan_cnt <= '0;
      digit    <= 2'd0;
    end else if (scan_cnt == CW'(SCAN_DIV - 1)) begin
      scan_cnt <= '0;
      digit    <= digit + 2'd1;
    end else begin
      scan_cnt <= scan_cnt + CW'(1);
    end
  end

  // Nibble select, digit 0 is the most significant.
  always_comb begin
    nibble = 4'h0;
    case (digit)
      2'd0:    nibble = product[15:12];
      2'd1:    nibble = product[11:8];
      2'd2:    nibble = product[7:4];
      2'd3:    nibble = product[3:0];
      default: nibble = 4'h0;
    endcase
  end

  // Segment and enable registers update together so the digits never ghost.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out  <= 7'b0111111;
      leds <= 4'b0001;
    end else begin
      out  <= seg_decode(nibble);
      leds <= 4'b0001 << digit;
    end
  end

  assign led1 = leds[0];
  assign led2 = leds[1];
  assign led3 = leds[2];
  assign led4 = leds[3];

endmodule

// File: tb/tb_multiplication_seq_led_board.sv
// Self-checking bench for multiplication_seq_led_board with a fast display scan.
module tb_multiplication_seq_led_board;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       done;
  logic [6:0] out;
  logic       led1, led2, led3, led4;

  int checks = 0;
  int errors = 0;
  logic [15:0] shown = 16'h0000;

  logic [6:0] seg_tab [16] = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
                               7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
                               7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
                               7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001};

  multiplication_seq_led_board #(.SCAN_DIV(4), .WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .done(done),
    .out(out), .led1(led1), .led2(led2), .led3(led3), .led4(led4)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] model(input logic [7:0] x, input logic [7:0] y);
    int p;
`ifdef MULT_SIGNED_EN
    p = $signed(x) * $signed(y);
`else
    p = int'(x) * int'(y);
`endif
    return p[15:0];
  endfunction

  // Expected segments for whichever digit the enables select.
  function automatic logic [6:0] exp_seg(input logic [15:0] val, input logic [3:0] lit);
    logic [3:0] nib;
    case (lit)
      4'b0001: nib = val[15:12];
      4'b0010: nib = val[11:8];
      4'b0100: nib = val[7:4];
      default: nib = val[3:0];
    endcase
    return seg_tab[nib];
  endfunction

  task automatic test_reset();
    rst = 1'b0; start = 1'b0; a = 8'd0; b = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b want=0", done); end
    checks++;
    if ({led4, led3, led2, led1} !== 4'b0001) begin
      errors++; $display("FAIL reset_leds got=%b want=0001", {led4, led3, led2, led1});
    end
    checks++;
    if (out !== 7'b0111111) begin errors++; $display("FAIL reset_out got=%b want=0111111", out); end
    @(negedge clk) rst = 1'b1;
    shown = 16'h0000;
  endtask

  // One operation; optionally re-pulses start mid-CALC with other switch values.
  task automatic run_op(input logic [7:0] x, input logic [7:0] y, input bit glitch,
                        input logic [7:0] gx, input logic [7:0] gy);
    logic [15:0] expv;
    logic [3:0]  lit;
    expv = model(x, y);
    a = x; b = y; start = 1'b1;
    for (int e = 0; e <= 12; e++) begin
      @(posedge clk); #1;
      if (e == 2) start = 1'b0;
      if (glitch && e == 4) begin a = gx; b = gy; start = 1'b1; end
      if (glitch && e == 6) start = 1'b0;
      if (e >= 3 && e < 12) begin
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL busy_done edge=%0d got=%b want=0", e, done); end
      end
      if (e == 12) begin
        checks++;
        if (done !== 1'b1) begin errors++; $display("FAIL latency_done edge=12 got=%b want=1", done); end
      end
      lit = {led4, led3, led2, led1};
      checks++;
      if ($countones(lit) != 1) begin
        errors++; $display("FAIL busy_onehot edge=%0d got=%b want=one-hot", e, lit);
      end else begin
        checks++;
        if (out !== exp_seg(shown, lit)) begin
          errors++; $display("FAIL busy_hold edge=%0d got=%b want=%b (old product %h)", e, out, exp_seg(shown, lit), shown);
        end
      end
    end
    for (int k = 0; k < 16; k++) begin
      @(posedge clk); #1;
      lit = {led4, led3, led2, led1};
      checks++;
      if (done !== 1'b1) begin errors++; $display("FAIL hold_done cyc=%0d got=%b want=1", k, done); end
      checks++;
      if ($countones(lit) != 1) begin
        errors++; $display("FAIL result_onehot got=%b want=one-hot", lit);
      end else begin
        checks++;
        if (out !== exp_seg(expv, lit)) begin
          errors++; $display("FAIL result a=%h b=%h leds=%b got=%b want=%b (product %h)", x, y, lit, out, exp_seg(expv, lit), expv);
        end
      end
    end
    shown = expv;
  endtask

  task automatic test_boundary();
    run_op(8'd13, 8'd11, 1'b0, 8'd0, 8'd0);
    run_op(8'd255, 8'd255, 1'b0, 8'd0, 8'd0);
    run_op(8'd0, 8'd200, 1'b0, 8'd0, 8'd0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 8; i++) begin
      run_op(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'b0, 8'd0, 8'd0);
    end
  endtask

  task automatic test_restart_ignored();
    run_op(8'd21, 8'd7, 1'b1, 8'd99, 8'd3);
    run_op(8'd99, 8'd3, 1'b0, 8'd0, 8'd0);
  endtask

  task automatic test_reset_mid();
    a = 8'd77; b = 8'd33; start = 1'b1;
    for (int e = 0; e <= 5; e++) begin
      @(posedge clk); #1;
      if (e == 2) start = 1'b0;
    end
    @(negedge clk) rst = 1'b0;
    #1;
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL midrst_done got=%b want=0", done); end
    checks++;
    if ({led4, led3, led2, led1} !== 4'b0001) begin
      errors++; $display("FAIL midrst_leds got=%b want=0001", {led4, led3, led2, led1});
    end
    checks++;
    if (out !== 7'b0111111) begin errors++; $display("FAIL midrst_out got=%b want=0111111", out); end
    @(negedge clk) rst = 1'b1;
    shown = 16'h0000;
    repeat (2) @(posedge clk);
    #1;
    run_op(8'd77, 8'd33, 1'b0, 8'd0, 8'd0);
  endtask

  task automatic test_scan();
    int prev, cur, run_len;
    bit first;
    logic [3:0] lit;
    run_op(8'd233, 8'd20, 1'b0, 8'd0, 8'd0);
    first = 1'b1; run_len = 0; prev = -1;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      lit = {led4, led3, led2, led1};
      cur = led1 ? 0 : led2 ? 1 : led3 ? 2 : 3;
      checks++;
      if (out !== exp_seg(shown, lit)) begin
        errors++; $display("FAIL scan_out leds=%b got=%b want=%b", lit, out, exp_seg(shown, lit));
      end
      if (prev < 0) begin
        run_len = 1;
      end else if (cur != prev) begin
        checks++;
        if (cur != (prev + 1) % 4) begin errors++; $display("FAIL scan_order got=%0d want=%0d", cur, (prev + 1) % 4); end
        if (!first) begin
          checks++;
          if (run_len != 4) begin errors++; $display("FAIL scan_dwell got=%0d want=4", run_len); end
        end
        first = 1'b0;
        run_len = 1;
      end else begin
        run_len++;
      end
      prev = cur;
    end
  endtask

`ifdef MULT_SIGNED_EN
  task automatic test_signed();
    run_op(8'hFD, 8'h05, 1'b0, 8'd0, 8'd0);
    run_op(8'h80, 8'h80, 1'b0, 8'd0, 8'd0);
    run_op(8'h7F, 8'h80, 1'b0, 8'd0, 8'd0);
  endtask
`endif

  initial begin
    test_reset();
    test_boundary();
    test_random();
    test_restart_ignored();
    test_reset_mid();
    test_scan();
`ifdef MULT_SIGNED_EN
    test_signed();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/multiplication_seq_led_board.md
Name: multiplication_seq_led_board

Overview:
- Sequential 8x8 shift-add multiplier that produces a 16-bit product.
- Operands come from board switches; a start button launches each operation.
- The product is shown as four hex digits on a time-multiplexed 7-segment display with one-hot digit enables.
- It is the inverse-operation counterpart of the sequential divider board block: the same start/done/segment/digit-enable board interface, with multiply in place of divide.

Parameters:
- SCAN_DIV, 50000, clocks per digit slot of the display scan (1 kHz per digit at 50 MHz); minimum 2.
- WIDTH, 8, operand width; the product is 2*WIDTH bits. The display covers 16 bits, so only the default WIDTH=8 is supported on the board.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-low reset
- start  input  1  start button, asynchronous to clk, active-high
- a  input  8  multiplicand (switches)
- b  input  8  multiplier (switches)
- done  output  1  high while a valid product is held; registered
- out  output  7  segment drive {g,f,e,d,c,b,a}, active-high; registered
- led1  output  1  digit enable, product[15:12] (most significant); active-high
- led2  output  1  digit enable, product[11:8]
- led3  output  1  digit enable, product[7:4]
- led4  output  1  digit enable, product[3:0]

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous and active-low. All flops clear immediately when rst=0.
- Reset values:
  - done=0, product=16'h0000, FSM=IDLE, scan counter=0, digit index=0.
  - Display shows 0000: led1=1, led2..4=0, out=7'b0111111.
- Start conditioning:
  - start passes through a 2-flop synchronizer.
  - A rising edge (stage2=1, stage3=0) gives a one-cycle internal start pulse.
  - Holding start high launches exactly one operation.
- FSM:
  - IDLE: on start pulse go to LOAD.
  - LOAD (1 cycle): capture a, b; clear accumulator; bit counter=0; done<=0.
  - CALC (exactly 8 cycles): if the multiplier LSB is 1, add the multiplicand to the upper accumulator half. Shift the accumulator right 1 with the carry-in, incrementing the bit counter. After count 7, go to DONE.
  - DONE: copy the accumulator to the product register; done<=1. On a start pulse go to LOAD, otherwise stay.
- Latency: with start first sampled high at edge 0, done is high after edge 12, and the product is valid in the same cycle. Exact, no tolerance.
- Start pulses in LOAD or CALC are ignored and not queued.
- Operands changing after LOAD have no effect on the current operation.
- The product register holds the last result during the next LOAD/CALC; the display never shows partial sums.
- done falls on the LOAD entry of the next operation.
- Reset mid-CALC: immediate abort, outputs to reset values, and the next start runs normally.
- Arithmetic: unsigned, no overflow possible (255*255=16'hFE01).
- Display scan:
  - The scan counter counts 0..SCAN_DIV-1; on wrap, the digit index advances 0->1->2->3->0.
  - Exactly one of led1..4 is high at any time (index 0 = led1).
  - out is the hex decode of the selected nibble, registered with the enable so both change on the same edge.
  - Decode table: 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111, A=1110111, b=1111100, C=0111001, d=1011110, E=1111001, F=1110001.

Optional Feature:
- Macro: MULT_SIGNED_EN.
- Defined:
  - a and b are two's complement.
  - LOAD captures their magnitudes and the sign XOR.
  - The 8 CALC cycles are unchanged.
  - DONE stores the two's-complement negation of the accumulator when the signs differ.
  - Latency is unchanged; -128*-128 = 16'h4000.
- Undefined: unsigned operation as described above. No extra logic is present.

Test Plan:
- a=13, b=11, start pulse -> done high exactly after edge 12; product 16'h008F; digits 0,0,8,F.
- a=255, b=255 -> 16'hFE01; a=0, b=200 -> 16'h0000 with done still asserting.
- Start re-pulsed during CALC with new switches -> ignored; the first result is reported, and a later start computes the new operands.
- rst low at edge 6 of an operation -> done=0, display 0000 immediately; the next start gives a correct result.
- SCAN_DIV=4, product 16'h1234 -> led1..led4 rotate every 4 clocks with out = 0000110, 1011011, 1001111, 1100110 respectively.
- With MULT_SIGNED_EN: a=8'hFD (-3), b=5 -> 16'hFFF1; a=8'h80, b=8'h80 -> 16'h4000.
